// File: rtl/shift_reg_with_valid.sv
// -----------------------------------------------------------------------------
// shift_reg_with_valid
//   Fixed-latency delay line carrying a data word and its valid flag through
//   `depth` register stages. It keeps side-band data aligned with a datapath of
//   known latency. Only the valid chain is reset; data is meaningful only
//   while out_vld is high.
//
// Parameters:
//   width  - data word width in bits (>= 1)
//   depth  - number of register stages / latency in cycles (>= 1)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, clears the valid chain only
//   in_vld    in   input valid
//   in_data   in   input data word [width-1:0]
//   out_vld   out  in_vld delayed by depth cycles (registered)
//   out_data  out  in_data delayed by depth cycles (registered)
//
// Build option:
//   SHIFT_REG_WITH_VALID_DATA_GATE_EN - when defined, each data stage loads
//   only when the word entering it is valid and otherwise holds its value,
//   cutting switching activity. Output for valid words is unchanged; out_data
//   while out_vld is low may differ from the ungated build.
// -----------------------------------------------------------------------------
module shift_reg_with_valid #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [width-1:0] in_data,
  output logic             out_vld,
  output logic [width-1:0] out_data
);

  logic [depth-1:0] vld_q;
  logic [depth-1:0] vld_d;
  logic [width-1:0] data_q [depth];
  logic [width-1:0] data_d [depth];

  // Valid chain: shifts every cycle, reset drops every in-flight token.
  always_comb begin
    vld_d = '0;
    if (!rst) begin
      vld_d[0] = in_vld;
      for (int unsigned i = 1; i < depth; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  // Data chain next-state.
  always_comb begin
    for (int unsigned i = 0; i < depth; i++) begin
      data_d[i] = data_q[i];
    end
`ifdef SHIFT_REG_WITH_VALID_DATA_GATE_EN
    // Each stage loads only when the word entering it is valid.
    if (in_vld && !rst) begin
      data_d[0] = in_data;
    end
    for (int unsigned i = 1; i < depth; i++) begin
      if (vld_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
`else
    // Plain shift register: every stage loads every cycle.
    data_d[0] = in_data;
    for (int unsigned i = 1; i < depth; i++) begin
      data_d[i] = data_q[i-1];
    end
`endif
  end

  always_ff @(posedge clk) begin
    vld_q <= vld_d;
  end

  // Data stages intentionally carry no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < depth; i++) begin
      data_q[i] <= data_d[i];
    end
  end

  assign out_vld  = vld_q[depth-1];
  assign out_data = data_q[depth-1];

endmodule

// File: tb/tb_shift_reg_with_valid.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_with_valid
//   Scoreboard bench for shift_reg_with_valid. Three instances with
//   (width, depth) = (8,8), (1,1), (32,3) share one stimulus stream. Each
//   accepted input word is queued with the cycle at which it must emerge;
//   a reset edge discards everything still in flight. A separate monitor
//   samples all outputs on the falling edge and compares against the queues.
// -----------------------------------------------------------------------------
module tb_shift_reg_with_valid;

  localparam int unsigned W0 = 8;
  localparam int unsigned D0 = 8;
  localparam int unsigned W1 = 1;
  localparam int unsigned D1 = 1;
  localparam int unsigned W2 = 32;
  localparam int unsigned D2 = 3;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } tok_t;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic [31:0]   din;
  logic          vld0, vld1, vld2;
  logic [W0-1:0] dout0;
  logic [W1-1:0] dout1;
  logic [W2-1:0] dout2;

  tok_t        sb [3][$];
  int unsigned edge_n    = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;
  bit          armed     = 1'b0;
  bit          stim_done = 1'b0;
  bit          mon_done  = 1'b0;

  shift_reg_with_valid #(.width(W0), .depth(D0)) u_dut0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(din[W0-1:0]),
    .out_vld(vld0), .out_data(dout0)
  );
  shift_reg_with_valid #(.width(W1), .depth(D1)) u_dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(din[W1-1:0]),
    .out_vld(vld1), .out_data(dout1)
  );
  shift_reg_with_valid #(.width(W2), .depth(D2)) u_dut2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(din[W2-1:0]),
    .out_vld(vld2), .out_data(dout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model: a word presented after edge k is due on the outputs
  // after edge k+depth, unless a reset edge falls in between.
  task automatic step(input logic r, input logic v, input logic [31:0] d);
    rst    = r;
    in_vld = v;
    din    = v ? d : 32'hxxxx_xxxx;
    if (r === 1'b0 && v === 1'b1) begin
      sb[0].push_back('{due: edge_n + D0, data: d});
      sb[1].push_back('{due: edge_n + D1, data: d});
      sb[2].push_back('{due: edge_n + D2, data: d});
    end
    @(posedge clk);
    if (r === 1'b1) begin
      for (int k = 0; k < 3; k++) sb[k].delete();
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_inst(input int k, input logic v, input logic [31:0] d,
                            input logic [31:0] mask);
    logic        exp_v;
    logic [31:0] exp_d;
    tok_t        t;
    exp_v = 1'b0;
    exp_d = 32'h0;
    while (sb[k].size() > 0 && sb[k][0].due < edge_n) begin
      t = sb[k].pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL lost_token inst%0d: data %h due edge %0d never emerged", k, t.data & mask, t.due);
    end
    if (sb[k].size() > 0 && sb[k][0].due == edge_n) begin
      t     = sb[k].pop_front();
      exp_v = 1'b1;
      exp_d = t.data;
    end
    n_checks++;
    if (v !== exp_v) begin
      n_errors++;
      $display("FAIL out_vld inst%0d edge %0d: got %b expected %b", k, edge_n, v, exp_v);
    end else if (exp_v) begin
      n_checks++;
      if ((d & mask) !== (exp_d & mask)) begin
        n_errors++;
        $display("FAIL out_data inst%0d edge %0d: got %h expected %h", k, edge_n, d & mask, exp_d & mask);
      end
    end
  endtask

  // Monitor: compares every output once per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check_inst(0, vld0, 32'(dout0), 32'h0000_00ff);
        check_inst(1, vld1, 32'(dout1), 32'h0000_0001);
        check_inst(2, vld2, 32'(dout2), 32'hffff_ffff);
      end
      if (stim_done && !mon_done) begin
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (sb[k].size() != 0) begin
            n_errors++;
            $display("FAIL drain inst%0d: %0d tokens left, expected 0", k, sb[k].size());
          end
        end
        mon_done = 1'b1;
      end
    end
  end

  initial begin
    rst    = 1'bx;
    in_vld = 1'b0;
    din    = 32'h0;

    // Power-up with unknown reset, then reset held for three cycles.
    for (int i = 0; i < 3; i++) step(1'bx, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    armed = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);

    // Single word.
    step(1'b0, 1'b1, 32'h0000_00a5);
    idle(10);

    // Back-to-back words.
    step(1'b0, 1'b1, 32'h0000_0001);
    step(1'b0, 1'b1, 32'h0000_0002);
    step(1'b0, 1'b1, 32'h0000_0003);
    idle(10);

    // Valid / bubble / valid.
    step(1'b0, 1'b1, 32'h0000_0011);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0033);
    idle(10);

    // Mid-stream reset flushes in-flight words; later words still flow.
    step(1'b0, 1'b1, 32'hdead_0040);
    step(1'b0, 1'b1, 32'hbeef_0041);
    step(1'b0, 1'b1, 32'h1234_5642);
    step(1'b0, 1'b1, 32'hcafe_0043);
    step(1'b1, 1'b1, 32'h0000_00ee);
    step(1'b0, 1'b1, 32'h0000_0055);
    step(1'b0, 1'b1, 32'h0000_0066);
    idle(10);

    // Randomized episodes: short reset, then random traffic.
    for (int ep = 0; ep < 3 * int'(D0); ep++) begin
      int nrst;
      nrst = int'($urandom_range(1, 2));
      for (int i = 0; i < nrst; i++) step(1'b1, 1'($urandom), $urandom);
      for (int i = 0; i < 3 * int'(D0); i++) begin
        step(1'b0, 1'($urandom_range(0, 3) != 0), $urandom);
      end
    end

    idle(int'(D0) + 2);
    stim_done = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
    if (!mon_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL monitor_timeout: drain check not reached, expected within 10 cycles");
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
